// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic isDivOp(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic isSignedOp(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and emit that quotient bit.
module div_step #(
  parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qBit_o
);

  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so trial fits in WIDTH+1
  // bits and a successful subtraction always fits back into WIDTH bits.
  assign trial  = {rem_i, bit_i};
  assign qBit_o = (trial >= {1'b0, divisor_i});
  assign rem_o  = qBit_o ? (trial[WIDTH-1:0] - divisor_i) : trial[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit owning the HI/LO registers; works on
// operand magnitudes and fixes signs in a single final cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  muldiv_op_t       mdop_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opReg_q, opReg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic isDiv_q, isDiv_d;
  logic negRes_q, negRes_d;
  logic negRem_q, negRem_d;
  logic divZero_q, divZero_d;
  logic done_q, done_d;

  logic signedOp;
  logic [WIDTH-1:0] srcaMag, srcbMag;
  logic [WIDTH:0] mulSum;
  logic [2*WIDTH-1:0] mulNext, divNext, prodFix;
  logic [WIDTH-1:0] divRem;
  logic divQ;
  logic [WIDTH-1:0] quoFix, remFix;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i    (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i    (acc_q[WIDTH-1]),
    .divisor_i(opReg_q),
    .rem_o    (divRem),
    .qBit_o   (divQ)
  );

  // acc holds {partial product, remaining multiplier} for multiply and
  // {partial remainder, dividend bits / quotient bits} for divide.
  always_comb begin
    signedOp = isSignedOp(mdop_i);
    srcaMag  = (signedOp && srca_i[WIDTH-1]) ? (~srca_i + 1'b1) : srca_i;
    srcbMag  = (signedOp && srcb_i[WIDTH-1]) ? (~srcb_i + 1'b1) : srcb_i;
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opReg_q} : '0);
    mulNext  = {mulSum, acc_q[WIDTH-1:1]};
    divNext  = {divRem, acc_q[WIDTH-2:0], divQ};
    prodFix  = negRes_q ? (~acc_q + 1'b1) : acc_q;
    remFix   = negRem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    if (divZero_q) begin
      quoFix = '1;
    end else begin
      quoFix = negRes_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opReg_d   = opReg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    isDiv_d   = isDiv_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          isDiv_d   = isDivOp(mdop_i);
          negRes_d  = signedOp && (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
          negRem_d  = signedOp && srca_i[WIDTH-1];
          divZero_d = (srcb_i == '0);
          cnt_d     = '0;
          if (isDivOp(mdop_i)) begin
            opReg_d = srcbMag;
            acc_d   = {{WIDTH{1'b0}}, srcaMag};
          end else begin
            opReg_d = srcaMag;
            acc_d   = {{WIDTH{1'b0}}, srcbMag};
          end
          state_d = CALC;
        end else begin
          if (wr_hi_i) hi_d = wd_i;
          if (wr_lo_i) lo_d = wd_i;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = isDiv_q ? divNext : mulNext;
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        if (isDiv_q) begin
          hi_d = remFix;
          lo_d = quoFix;
        end else begin
          hi_d = prodFix[2*WIDTH-1:WIDTH];
          lo_d = prodFix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opReg_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opReg_q   <= opReg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      isDiv_q   <= isDiv_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      done_q    <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  muldiv_op_t  mdop;
  logic [31:0] srca, srcb, wd;
  logic        wr_hi, wr_lo;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .mdop_i (mdop),
    .srca_i (srca),
    .srcb_i (srcb),
    .wr_hi_i(wr_hi),
    .wr_lo_i(wr_lo),
    .wd_i   (wd),
    .hi_o   (hi),
    .lo_o   (lo),
    .busy_o (busy),
    .done_o (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Launches one operation and watches busy/done for a fixed window of cycles.
  task automatic applyStimulus(input muldiv_op_t op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi,
                               input logic [31:0] expLo, input bit pokeBusy,
                               input bit wrLoWithStart, input string tag);
    int busyCnt = 0;
    int doneCnt = 0;
    int doneAt  = 0;
    logic [31:0] prevHi;
    logic [31:0] prevLo;
    @(negedge clk);
    prevHi = hi;
    prevLo = lo;
    start = 1'b1;
    mdop  = op;
    srca  = a;
    srcb  = b;
    if (wrLoWithStart) begin
      wr_lo = 1'b1;
      wd    = 32'h5555_5555;
    end
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        wr_lo = 1'b0;
        if (wrLoWithStart) checkOutput({tag, " startWinsLo"}, lo, prevLo);
      end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        doneAt = k;
      end
      if (pokeBusy && k == 5) begin
        wr_hi = 1'b1;
        wd    = 32'h0000_1234;
        start = 1'b1;
        mdop  = MULTU;
        srca  = 32'd9;
        srcb  = 32'd9;
      end
      if (pokeBusy && k == 6) begin
        wr_hi = 1'b0;
        start = 1'b0;
      end
      if (pokeBusy && k == 20) checkOutput({tag, " hiHold"}, hi, prevHi);
    end
    checkOutput({tag, " hi"}, hi, expHi);
    checkOutput({tag, " lo"}, lo, expLo);
    checkOutput({tag, " busyCycles"}, 32'(busyCnt), 32'd33);
    checkOutput({tag, " donePulses"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, " doneCycle"}, 32'(doneAt), 32'd34);
  endtask

  initial begin
    logic [31:0] prevHi;
    int doneSeen;
    rst_n = 1'b0;
    start = 1'b0;
    mdop  = MULTU;
    srca  = '0;
    srcb  = '0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wd    = '0;
    #12;
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, "multuMax");
    applyStimulus(MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, "multNeg1");
    applyStimulus(DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1, 0, "divu100by7");
    applyStimulus(DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, "divNeg7by2");
    applyStimulus(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0, "divOverflow");
    applyStimulus(DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0, 0, "divuByZero");
    applyStimulus(DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 0, "divNegByZero");
    applyStimulus(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 0, "multMinSq");
    applyStimulus(MULT,  32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, "mult7xNeg3");
    applyStimulus(DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 0, "div7byNeg2");

    @(negedge clk);
    prevHi = hi;
    wr_lo  = 1'b1;
    wd     = 32'h0000_ABCD;
    @(negedge clk);
    wr_lo = 1'b0;
    checkOutput("mtlo lo", lo, 32'h0000_ABCD);
    checkOutput("mtlo hiKept", hi, prevHi);

    applyStimulus(MULTU, 32'd3, 32'd5, 32'h0, 32'd15, 0, 1, "startPlusMtlo");

    @(negedge clk);
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wd    = 32'h0000_0077;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    checkOutput("mtBoth hi", hi, 32'h0000_0077);
    checkOutput("mtBoth lo", lo, 32'h0000_0077);

    start = 1'b1;
    mdop  = MULTU;
    srca  = 32'h0000_FFFF;
    srcb  = 32'h0000_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset hi", hi, 32'h0);
    checkOutput("midReset lo", lo, 32'h0);
    checkOutput("midReset busy", 32'(busy), 32'h0);
    doneSeen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("midReset noDone", 32'(doneSeen), 32'h0);
    checkOutput("midReset idleBusy", 32'(busy), 32'h0);

    applyStimulus(MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 0, 0, "multuAfterReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
